wave_sample_arbiter: RTL

//   Shares one waveform-RAM write port among four sample producers: ch0 = mixed codec sample,
//   ch1..ch3 = per-note samples. Producers strobe together on each new sample; every channel is

---
 rtl/wave_sample_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wave_sample_arbiter.sv
// Four buffered sample producers share one waveform-RAM write port, drained round-robin.
// Each channel owns a wrapping write-address counter, giving four independent circular buffers.
module wave_sample_arbiter #(
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 1,
  parameter int ADDR_W     = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [3:0]            in_valid,
  input  logic [4*SAMPLE_W-1:0] in_sample,
  input  logic                  wr_ready,
  output logic                  wr_en,
  output logic [1:0]            wr_chan,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [SAMPLE_W-1:0]   wr_data,
  output logic [3:0]            overflow,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [SAMPLE_W-1:0] mem      [4][DEPTH];
  logic [PTR_W-1:0]    wptr     [4];
  logic [PTR_W-1:0]    rptr     [4];
  logic [CNT_W-1:0]    cnt      [4];
  logic [ADDR_W-1:0]   addr_cnt [4];
  logic [1:0]          rr_ptr;

  logic [3:0] nonempty;
  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] pop;
  logic       load_en;
  logic       win_valid;
  logic [1:0] win_chan;
  logic [1:0] idx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = (cnt[i] != '0);
      full[i]     = (cnt[i] == CNT_W'(DEPTH));
    end
  end

  // Valid/ready: the output register presents a write while wr_en=1 and holds it unchanged
  // until a cycle with wr_ready=1; it may reload in that same cycle, so writes can go every cycle.
  always_comb begin
    load_en   = !wr_en || wr_ready;
    win_valid = 1'b0;
    win_chan  = 2'd0;
    idx       = 2'd0;
    // Scan backwards so the last assignment is the first non-empty channel from rr_ptr.
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (nonempty[idx]) begin
        win_valid = 1'b1;
        win_chan  = idx;
      end
    end
    pop = 4'b0000;
    if (load_en && win_valid) pop[win_chan] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push[i] = in_valid[i] && (!full[i] || pop[i]);
    end
    busy = (|nonempty) || wr_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_chan  <= 2'd0;
      wr_addr  <= '0;
      wr_data  <= '0;
      overflow <= 4'b0000;
      rr_ptr   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        wptr[i]     <= '0;
        rptr[i]     <= '0;
        cnt[i]      <= '0;
        addr_cnt[i] <= '0;
        for (int j = 0; j < DEPTH; j++) mem[i][j] <= '0;
      end
    end else if (clear) begin
      wr_en    <= 1'b0;
      wr_chan  <= 2'd0;
      wr_addr  <= '0;
      wr_data  <= '0;
      overflow <= 4'b0000;
      rr_ptr   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        wptr[i]     <= '0;
        rptr[i]     <= '0;
        cnt[i]      <= '0;
        addr_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          mem[i][wptr[i]] <= in_sample[i*SAMPLE_W +: SAMPLE_W];
          wptr[i]         <= wptr[i] + PTR_W'(1);
        end
        if (pop[i]) rptr[i] <= rptr[i] + PTR_W'(1);
        cnt[i] <= cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        if (in_valid[i] && !push[i]) overflow[i] <= 1'b1;
      end
      if (load_en) begin
        wr_en <= win_valid;
        if (win_valid) begin
          wr_chan            <= win_chan;
          wr_addr            <= addr_cnt[win_chan];
          wr_data            <= mem[win_chan][rptr[win_chan]];
          addr_cnt[win_chan] <= addr_cnt[win_chan] + ADDR_W'(1);
          rr_ptr             <= win_chan + 2'd1;
        end
      end
    end
  end

endmodule
